// File: rtl/dcm_ctrl_pkg.sv
// Shared types and constants for the DCM_SP reset sequencer.
package dcm_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_RST_HOLD  = 3'd0,
        ST_WAIT_LOCK = 3'd1,
        ST_STABILIZE = 3'd2,
        ST_RUN       = 3'd3,
        ST_FAULT     = 3'd4
    } state_e;

    // DCM_SP STATUS bit positions
    localparam int unsigned CLKIN_STOPPED = 1;
    localparam int unsigned CLKFX_STOPPED = 2;

    localparam int unsigned RETRY_W = 2;

    // Width of a counter that must reach (largest timing parameter - 1)
    function automatic int unsigned cnt_width(input int unsigned a,
                                              input int unsigned b,
                                              input int unsigned c);
        int unsigned m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        if (m <= 2) return 1;
        return $clog2(m);
    endfunction

endpackage

// File: rtl/dcm_reset_ctrl_if.sv
// DCM-facing and system-facing signals of the reset sequencer.
interface dcm_reset_ctrl_if;
    import dcm_ctrl_pkg::*;

    logic               LOCKED;
    logic [7:0]         STATUS;
    logic               RESTART;
    logic               DCM_RST;
    logic               SYS_RESET;
    logic               READY;
    logic               FAULT;
    logic               LOSS_EVT;
    logic [RETRY_W-1:0] RETRY_CNT;

    // Controller side
    modport master (
        input  LOCKED, STATUS, RESTART,
        output DCM_RST, SYS_RESET, READY, FAULT, LOSS_EVT, RETRY_CNT
    );

    // DCM / downstream side
    modport slave (
        output LOCKED, STATUS, RESTART,
        input  DCM_RST, SYS_RESET, READY, FAULT, LOSS_EVT, RETRY_CNT
    );

endinterface

// File: rtl/sync_2ff.sv
// Two-flop synchroniser for signals asynchronous to clk_i.
module sync_2ff #(
    parameter int unsigned WIDTH = 1
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic [WIDTH-1:0] d_i,
    output logic [WIDTH-1:0] q_o
);

    logic [WIDTH-1:0] meta_q;
    logic [WIDTH-1:0] sync_q;

    // Capture stage followed by resolution stage
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            meta_q <= '0;
            sync_q <= '0;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;

endmodule

// File: rtl/dcm_reset_ctrl.sv
// DCM_SP reset sequencer: holds DCM RST, waits for LOCKED with timeout and
// bounded retries, requires a stable-lock window before releasing SYS_RESET,
// and re-sequences on lock loss.
// Optional build macro DCM_STATUS_MON_EN: synchronised STATUS[1]/STATUS[2]
// fail a stabilising attempt and count as lock loss in RUN.
module dcm_reset_ctrl
    import dcm_ctrl_pkg::*;
#(
    parameter int unsigned RST_HOLD_CYCLES = 4,
    parameter int unsigned LOCK_TIMEOUT    = 1024,
    parameter int unsigned STABLE_CYCLES   = 16,
    parameter int unsigned MAX_RETRIES     = 3
) (
    input  logic              CLK,
    input  logic              RESET,
    dcm_reset_ctrl_if.master  dcm
);

    localparam int unsigned CNT_W = cnt_width(RST_HOLD_CYCLES, LOCK_TIMEOUT, STABLE_CYCLES);

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [RETRY_W-1:0] retry_q, retry_d;
    logic               attempt_fail;

    logic dcm_rst_q, dcm_rst_d;
    logic sys_reset_q, sys_reset_d;
    logic ready_q, ready_d;
    logic fault_q, fault_d;
    logic loss_q, loss_d;

    logic [0:0] s_lock_v;
    logic       s_lock;
    logic       status_bad;
    logic       status_unused;

    sync_2ff #(.WIDTH(1)) u_lock_sync (
        .clk_i (CLK),
        .rst_i (RESET),
        .d_i   (dcm.LOCKED),
        .q_o   (s_lock_v)
    );
    assign s_lock = s_lock_v[0];

`ifdef DCM_STATUS_MON_EN
    logic [1:0] s_status;

    sync_2ff #(.WIDTH(2)) u_status_sync (
        .clk_i (CLK),
        .rst_i (RESET),
        .d_i   ({dcm.STATUS[CLKFX_STOPPED], dcm.STATUS[CLKIN_STOPPED]}),
        .q_o   (s_status)
    );
    assign status_bad    = |s_status;
    assign status_unused = ^{dcm.STATUS[7:3], dcm.STATUS[0]};
`else
    assign status_bad    = 1'b0;
    assign status_unused = ^dcm.STATUS;
`endif

    // State, counters and registered outputs
    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q     <= ST_RST_HOLD;
            cnt_q       <= '0;
            retry_q     <= '0;
            dcm_rst_q   <= 1'b1;
            sys_reset_q <= 1'b1;
            ready_q     <= 1'b0;
            fault_q     <= 1'b0;
            loss_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            retry_q     <= retry_d;
            dcm_rst_q   <= dcm_rst_d;
            sys_reset_q <= sys_reset_d;
            ready_q     <= ready_d;
            fault_q     <= fault_d;
            loss_q      <= loss_d;
        end
    end

    // Next state, phase counter and retry bookkeeping
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q + CNT_W'(1);
        retry_d      = retry_q;
        attempt_fail = 1'b0;

        case (state_q)
            ST_RST_HOLD: begin
                if (cnt_q == CNT_W'(RST_HOLD_CYCLES - 1)) state_d = ST_WAIT_LOCK;
            end
            ST_WAIT_LOCK: begin
                if (s_lock)                                    state_d = ST_STABILIZE;
                else if (cnt_q == CNT_W'(LOCK_TIMEOUT - 1))    attempt_fail = 1'b1;
            end
            ST_STABILIZE: begin
                if (!s_lock || status_bad)                     attempt_fail = 1'b1;
                else if (cnt_q == CNT_W'(STABLE_CYCLES - 1))   state_d = ST_RUN;
            end
            ST_RUN: begin
                if (!s_lock || status_bad) state_d = ST_RST_HOLD;
            end
            ST_FAULT: begin
                if (dcm.RESTART) begin
                    state_d = ST_RST_HOLD;
                    retry_d = '0;
                end
            end
            default: state_d = ST_RST_HOLD;
        endcase

        if (attempt_fail) begin
            if (retry_q == RETRY_W'(MAX_RETRIES)) begin
                state_d = ST_FAULT;
            end else begin
                state_d = ST_RST_HOLD;
                if (retry_q != '1) retry_d = retry_q + RETRY_W'(1);
            end
        end

        if (state_d == ST_RUN)   retry_d = '0;
        if (state_d != state_q)  cnt_d   = '0;
    end

    // Output decode from the next state so outputs move with the state
    always_comb begin
        dcm_rst_d   = 1'b1;
        sys_reset_d = 1'b1;
        ready_d     = 1'b0;
        fault_d     = 1'b0;
        loss_d      = (state_q == ST_RUN) && (state_d == ST_RST_HOLD);

        case (state_d)
            ST_WAIT_LOCK, ST_STABILIZE: dcm_rst_d = 1'b0;
            ST_RUN: begin
                dcm_rst_d   = 1'b0;
                sys_reset_d = 1'b0;
                ready_d     = 1'b1;
            end
            ST_FAULT: fault_d = 1'b1;
            default: ;
        endcase
    end

    assign dcm.DCM_RST   = dcm_rst_q;
    assign dcm.SYS_RESET = sys_reset_q;
    assign dcm.READY     = ready_q;
    assign dcm.FAULT     = fault_q;
    assign dcm.LOSS_EVT  = loss_q;
    assign dcm.RETRY_CNT = retry_q;

endmodule

// File: doc/dcm_reset_ctrl.md
Name: dcm_reset_ctrl

Overview:
- Sequences the DCM_SP clocking primitive inside the clock wizard.
- Drives the DCM's RST input and waits for LOCKED, with timeout and bounded retries.
- Requires LOCKED to stay high through a stabilisation window before releasing the synchronous system reset.
- Runs on the free-running board clock ahead of the wizard. It re-sequences automatically if lock is lost and latches a FAULT indication when retries are exhausted.

Parameters:
RST_HOLD_CYCLES, 4, cycles DCM_RST is held high per attempt (DCM_SP needs at least 3 CLKIN cycles); must be at least 3
LOCK_TIMEOUT, 1024, cycles allowed in WAIT_LOCK before the attempt is declared failed
STABLE_CYCLES, 16, consecutive synchronised-LOCKED cycles required before SYS_RESET is released
MAX_RETRIES, 3, failed attempts tolerated after the first; the next failure enters FAULT

Ports:
CLK  input  1  free-running board clock; all logic on the rising edge
RESET  input  1  synchronous, active-high reset
LOCKED  input  1  DCM LOCKED; asynchronous to CLK
STATUS  input  8  DCM STATUS; bit1 = CLKIN stopped, bit2 = CLKFX stopped
RESTART  input  1  single-cycle pulse; leaves FAULT and starts a fresh sequence
DCM_RST  output  1  to DCM RST
SYS_RESET  output  1  synchronous active-high reset for downstream logic
READY  output  1  high only in RUN
FAULT  output  1  high only in FAULT
LOSS_EVT  output  1  one-cycle pulse when lock is lost in RUN
RETRY_CNT  output  2  failed attempts in the current sequence, saturating

Behaviour:
- Reset (RESET=1 at an edge):
  - state=RST_HOLD; counter=0; RETRY_CNT=0; synchroniser flops=0.
  - DCM_RST=1, SYS_RESET=1, READY=0, FAULT=0, LOSS_EVT=0.
  - RESET mid-operation overrides every state, FAULT included.
- LOCKED passes through a 2-flop synchroniser to give s_lock, 2 cycles of latency. STATUS bits pass through the same synchroniser style.
- All outputs are registered and decoded from the next state, so each output changes on the same edge the state changes.
- Counter width is $clog2 of the largest of the timing parameters. The counter clears on every state change.
- RST_HOLD: DCM_RST=1, SYS_RESET=1. When the counter reaches RST_HOLD_CYCLES-1, go to WAIT_LOCK.
- WAIT_LOCK: DCM_RST=0.
  - s_lock=1: go to STABILIZE.
  - Otherwise, when the counter reaches LOCK_TIMEOUT-1, the attempt has failed:
    - RETRY_CNT==MAX_RETRIES: go to FAULT.
    - Otherwise: increment RETRY_CNT and go to RST_HOLD.
- STABILIZE: counts while s_lock=1.
  - s_lock=0: treated as a failed attempt (same retry rule as WAIT_LOCK).
  - Counter reaches STABLE_CYCLES-1: go to RUN.
  - Result: SYS_RESET falls 2+STABLE_CYCLES edges after the first edge that samples LOCKED=1.
- RUN: SYS_RESET=0, READY=1, RETRY_CNT cleared on entry.
  - s_lock=0 (or a status fault, see Optional Feature): go to RST_HOLD.
  - On that transition: LOSS_EVT=1 for one cycle, SYS_RESET=1 and DCM_RST=1 on the same edge.
  - RETRY_CNT stays 0 for the new sequence.
- FAULT: DCM_RST=1, SYS_RESET=1, FAULT=1. Terminal until RESET or RESTART.
  - RESTART in FAULT: RETRY_CNT=0, go to RST_HOLD.
  - RESTART in any other state is ignored.
- Simultaneous events:
  - RESET has priority over RESTART.
  - In WAIT_LOCK, s_lock=1 on the timeout cycle wins: go to STABILIZE.
- RETRY_CNT saturates at 3.

Optional Feature:
- Macro: DCM_STATUS_MON_EN.
- Defined:
  - Synchronised STATUS[1] or STATUS[2] high in STABILIZE counts as a failed attempt.
  - Either bit high in RUN is treated as lock loss (LOSS_EVT, then RST_HOLD).
  - STATUS is ignored in all other states.
- Undefined: the STATUS port exists but is unused, and only LOCKED drives transitions.

Decomposition:
- Package dcm_ctrl_pkg:
  - state encoding: RST_HOLD, WAIT_LOCK, STABILIZE, RUN, FAULT;
  - STATUS bit index constants (CLKIN_STOPPED=1, CLKFX_STOPPED=2);
  - the counter-width function.
- Sub-module sync_2ff (parameterised WIDTH), used for LOCKED and STATUS.
- The FSM and counters live in the top module.

Test Plan:
- Nominal lock:
  - Stimulus: defaults; release RESET at edge 0; raise LOCKED at edge 50.
  - Response: DCM_RST high for edges 0-3 and low from edge 4; SYS_RESET falls and READY rises at edge 68; RETRY_CNT=0.
- Timeout retry:
  - Stimulus: LOCKED held low for 1100 cycles, then high.
  - Response: one timeout; RETRY_CNT=1; DCM_RST pulses high for 4 cycles at edge 1028; lock is then achieved and READY=1.
- Exhaustion:
  - Stimulus: LOCKED held low permanently.
  - Response: 4 timeouts, then FAULT=1 with DCM_RST=1 and SYS_RESET=1 held for 5000 cycles.
  - Then a RESTART pulse gives FAULT=0, RETRY_CNT=0 and RST_HOLD.
- Glitch in STABILIZE:
  - Stimulus: LOCKED high for 8 cycles, low for 1, then high.
  - Response: RETRY_CNT=1, a new RST_HOLD, and READY delayed by a full sequence.
- Loss in RUN:
  - Stimulus: drop LOCKED while READY=1.
  - Response: exactly 2 cycles later, a single LOSS_EVT pulse with SYS_RESET=1, DCM_RST=1 and READY=0 on the same edge.
- Status monitor, with DCM_STATUS_MON_EN:
  - Stimulus: STATUS=8'h02 in RUN.
  - Response: same as loss in RUN.
  - Without the macro: no reaction.
